// File: rtl/pipe_hazard_ctrl_if.sv
// Stall/flush control bundle between the pipeline front end (master) and
// pipe_hazard_ctrl (slave). Optional counter outputs are present only when
// PIPE_HAZARD_CTRL_PERF_EN is defined.
interface pipe_hazard_ctrl_if #(
   parameter int GPR_ADDR_W = 5,
   parameter int PERF_CNT_W = 32
);
   logic                  cpu_en;
   logic [GPR_ADDR_W-1:0] id_rs1_addr;
   logic [GPR_ADDR_W-1:0] id_rs2_addr;
   logic                  id_rs1_rd_en;
   logic                  id_rs2_rd_en;
   logic                  load_in_ex_mem;
   logic [GPR_ADDR_W-1:0] ex_dst_addr;
   logic                  dmem_req;
   logic                  dmem_ack;
   logic                  branch_taken;
   logic                  trap_req;

   logic                  if_stall, id_stall, ex_stall, mem_stall;
   logic                  if_flush, id_flush, ex_flush, mem_flush;
   logic                  trap_redirect;
   logic [1:0]            ctrl_state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [PERF_CNT_W-1:0] perf_lu_stall_cnt;
   logic [PERF_CNT_W-1:0] perf_mem_stall_cnt;
   logic [PERF_CNT_W-1:0] perf_flush_cnt;
`endif

   modport master (
      output cpu_en, id_rs1_addr, id_rs2_addr, id_rs1_rd_en, id_rs2_rd_en,
             load_in_ex_mem, ex_dst_addr, dmem_req, dmem_ack, branch_taken, trap_req,
      input  if_stall, id_stall, ex_stall, mem_stall,
             if_flush, id_flush, ex_flush, mem_flush, trap_redirect, ctrl_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      , input perf_lu_stall_cnt, perf_mem_stall_cnt, perf_flush_cnt
`endif
   );

   modport slave (
      input  cpu_en, id_rs1_addr, id_rs2_addr, id_rs1_rd_en, id_rs2_rd_en,
             load_in_ex_mem, ex_dst_addr, dmem_req, dmem_ack, branch_taken, trap_req,
      output if_stall, id_stall, ex_stall, mem_stall,
             if_flush, id_flush, ex_flush, mem_flush, trap_redirect, ctrl_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      , output perf_lu_stall_cnt, perf_mem_stall_cnt, perf_flush_cnt
`endif
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Load-use bubbles, memory-wait freeze, branch squash and trap flush/redirect.
// Optional performance counters: define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
   parameter int GPR_ADDR_W = 5,
   parameter int PERF_CNT_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   pipe_hazard_ctrl_if.slave   hz
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_TRAP     = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_trap_pend;

   state_t                w_state_nxt;
   logic                  w_trap_pend_nxt;
   logic [GPR_ADDR_W-1:0] w_dst;
   logic                  w_hazard;
   logic                  w_if_stall, w_id_stall, w_ex_stall, w_mem_stall;
   logic                  w_if_flush, w_id_flush, w_ex_flush, w_mem_flush;
   logic                  w_redirect;
   logic                  w_lu_bubble;   // load-use bubble inserted this cycle
   logic                  w_mem_frz;     // pipe frozen on a data-memory access
   logic                  w_flush_evt;   // branch squash or trap flush

   assign w_dst = hz.ex_dst_addr;

   // Load-use hazard: x0 is never a real dependency
   assign w_hazard = hz.load_in_ex_mem && (w_dst != '0) &&
                     ((hz.id_rs1_rd_en && (hz.id_rs1_addr == w_dst)) ||
                      (hz.id_rs2_rd_en && (hz.id_rs2_addr == w_dst)));

   // State and pending-trap registers; everything holds while the core is disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_trap_pend <= 1'b0;
      end else if (hz.cpu_en) begin
         r_state     <= w_state_nxt;
         r_trap_pend <= w_trap_pend_nxt;
      end
   end

   // Next-state and stage controls, both purely from current state and inputs
   always_comb begin
      w_state_nxt     = r_state;
      w_trap_pend_nxt = r_trap_pend;
      w_if_stall      = 1'b0;
      w_id_stall      = 1'b0;
      w_ex_stall      = 1'b0;
      w_mem_stall     = 1'b0;
      w_if_flush      = 1'b0;
      w_id_flush      = 1'b0;
      w_ex_flush      = 1'b0;
      w_mem_flush     = 1'b0;
      w_redirect      = 1'b0;
      w_lu_bubble     = 1'b0;
      w_mem_frz       = 1'b0;
      w_flush_evt     = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (hz.trap_req) begin
               // Trap wins outright; everything else this cycle is dropped
               w_state_nxt = ST_TRAP;
            end else if (hz.dmem_req && !hz.dmem_ack) begin
               w_state_nxt = ST_MEM_WAIT;
               w_if_stall  = 1'b1;
               w_id_stall  = 1'b1;
               w_ex_stall  = 1'b1;
               w_mem_stall = 1'b1;
               w_mem_frz   = 1'b1;
            end else if (hz.branch_taken) begin
               // Squashing IF/ID also kills any load-use consumer in ID
               w_if_flush  = 1'b1;
               w_id_flush  = 1'b1;
               w_flush_evt = 1'b1;
            end else if (w_hazard) begin
               // Hold IF/ID one cycle and drop a bubble into EX; the load
               // moves on, so the hazard clears by itself next cycle
               w_if_stall  = 1'b1;
               w_id_stall  = 1'b1;
               w_ex_flush  = 1'b1;
               w_lu_bubble = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            // The access is never abandoned; a trap is remembered instead
            w_if_stall  = 1'b1;
            w_id_stall  = 1'b1;
            w_ex_stall  = 1'b1;
            w_mem_stall = 1'b1;
            w_mem_frz   = 1'b1;
            if (hz.trap_req)
               w_trap_pend_nxt = 1'b1;
            if (hz.dmem_ack)
               w_state_nxt = (r_trap_pend || hz.trap_req) ? ST_TRAP : ST_RUN;
         end
         ST_TRAP: begin
            w_if_flush      = 1'b1;
            w_id_flush      = 1'b1;
            w_ex_flush      = 1'b1;
            w_mem_flush     = 1'b1;
            w_redirect      = 1'b1;
            w_flush_evt     = 1'b1;
            w_trap_pend_nxt = 1'b0;
            w_state_nxt     = ST_RUN;
         end
         default: begin
            // Unused encoding: recover quietly
            w_trap_pend_nxt = 1'b0;
            w_state_nxt     = ST_RUN;
         end
      endcase
   end

   assign hz.if_stall      = w_if_stall;
   assign hz.id_stall      = w_id_stall;
   assign hz.ex_stall      = w_ex_stall;
   assign hz.mem_stall     = w_mem_stall;
   assign hz.if_flush      = w_if_flush;
   assign hz.id_flush      = w_id_flush;
   assign hz.ex_flush      = w_ex_flush;
   assign hz.mem_flush     = w_mem_flush;
   assign hz.trap_redirect = w_redirect;
   assign hz.ctrl_state    = r_state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [PERF_CNT_W-1:0] r_lu_cnt, r_mem_cnt, r_flush_cnt;

   // Saturating event counters, advancing only on enabled clocks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lu_cnt    <= '0;
         r_mem_cnt   <= '0;
         r_flush_cnt <= '0;
      end else if (hz.cpu_en) begin
         if (w_lu_bubble && (r_lu_cnt != '1))
            r_lu_cnt <= r_lu_cnt + PERF_CNT_W'(1);
         if (w_mem_frz && (r_mem_cnt != '1))
            r_mem_cnt <= r_mem_cnt + PERF_CNT_W'(1);
         if (w_flush_evt && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + PERF_CNT_W'(1);
      end
   end

   assign hz.perf_lu_stall_cnt  = r_lu_cnt;
   assign hz.perf_mem_stall_cnt = r_mem_cnt;
   assign hz.perf_flush_cnt     = r_flush_cnt;
`else
   logic w_unused_evt;
   assign w_unused_evt = w_lu_bubble ^ w_mem_frz ^ w_flush_evt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Inputs change on the falling edge,
// outputs are sampled 1ns later, state advances on the rising edge.
module tb_pipe_hazard_ctrl;
   // {if_stall,id_stall,ex_stall,mem_stall, if_flush,id_flush,ex_flush,mem_flush, trap_redirect}
   localparam logic [8:0] C_NONE  = 9'b0000_0000_0;
   localparam logic [8:0] C_STALL = 9'b1111_0000_0;
   localparam logic [8:0] C_LU    = 9'b1100_0010_0;
   localparam logic [8:0] C_BR    = 9'b0000_1100_0;
   localparam logic [8:0] C_TRAP  = 9'b0000_1111_1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   pipe_hazard_ctrl_if #(.GPR_ADDR_W(5), .PERF_CNT_W(32)) hz();

   pipe_hazard_ctrl #(.GPR_ADDR_W(5), .PERF_CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] ctl();
      return {hz.if_stall, hz.id_stall, hz.ex_stall, hz.mem_stall,
              hz.if_flush, hz.id_flush, hz.ex_flush, hz.mem_flush, hz.trap_redirect};
   endfunction

   task automatic idle_inputs();
      hz.cpu_en = 1'b1;
      hz.id_rs1_addr = '0; hz.id_rs2_addr = '0;
      hz.id_rs1_rd_en = 1'b0; hz.id_rs2_rd_en = 1'b0;
      hz.load_in_ex_mem = 1'b0; hz.ex_dst_addr = '0;
      hz.dmem_req = 1'b0; hz.dmem_ack = 1'b0;
      hz.branch_taken = 1'b0; hz.trap_req = 1'b0;
   endtask

   // Next cycle: inputs go idle at the falling edge, settle 1ns
   task automatic cyc();
      @(negedge clk);
      idle_inputs();
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_total++; if (hz.ctrl_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", hz.ctrl_state); else n_pass++;
      n_total++; if (ctl() !== C_NONE) $display("FAIL reset_ctl got=%b exp=%b", ctl(), C_NONE); else n_pass++;
      rst_n = 1'b1;
      cyc();
      n_total++; if (ctl() !== C_NONE || hz.ctrl_state !== 2'd0)
         $display("FAIL idle_run got=%b/%0d exp=%b/0", ctl(), hz.ctrl_state, C_NONE); else n_pass++;
   endtask

   task automatic test_load_use();
      cyc();
      hz.load_in_ex_mem = 1'b1; hz.ex_dst_addr = 5'd5; hz.id_rs2_rd_en = 1'b1; hz.id_rs2_addr = 5'd5; #1;
      n_total++; if (ctl() !== C_LU) $display("FAIL lu_rs2 got=%b exp=%b", ctl(), C_LU); else n_pass++;
      cyc();  // load has moved on
      n_total++; if (ctl() !== C_NONE || hz.ctrl_state !== 2'd0)
         $display("FAIL lu_one_bubble got=%b/%0d exp=%b/0", ctl(), hz.ctrl_state, C_NONE); else n_pass++;
      hz.load_in_ex_mem = 1'b1; hz.ex_dst_addr = 5'd7; hz.id_rs1_rd_en = 1'b1; hz.id_rs1_addr = 5'd7; #1;
      n_total++; if (ctl() !== C_LU) $display("FAIL lu_rs1 got=%b exp=%b", ctl(), C_LU); else n_pass++;
      cyc();
      hz.load_in_ex_mem = 1'b1; hz.ex_dst_addr = 5'd0; hz.id_rs2_rd_en = 1'b1; hz.id_rs2_addr = 5'd0; #1;
      n_total++; if (ctl() !== C_NONE) $display("FAIL lu_x0 got=%b exp=%b", ctl(), C_NONE); else n_pass++;
      cyc();
      hz.load_in_ex_mem = 1'b1; hz.ex_dst_addr = 5'd9; hz.id_rs2_rd_en = 1'b0; hz.id_rs2_addr = 5'd9; #1;
      n_total++; if (ctl() !== C_NONE) $display("FAIL lu_no_rden got=%b exp=%b", ctl(), C_NONE); else n_pass++;
      cyc();
      hz.load_in_ex_mem = 1'b0; hz.ex_dst_addr = 5'd9; hz.id_rs1_rd_en = 1'b1; hz.id_rs1_addr = 5'd9; #1;
      n_total++; if (ctl() !== C_NONE) $display("FAIL lu_no_load got=%b exp=%b", ctl(), C_NONE); else n_pass++;
   endtask

   task automatic test_mem_wait();
      cyc();
      hz.dmem_req = 1'b1; #1;
      n_total++; if (ctl() !== C_STALL || hz.ctrl_state !== 2'd0)
         $display("FAIL mw_issue got=%b/%0d exp=%b/0", ctl(), hz.ctrl_state, C_STALL); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (i == 1) begin hz.branch_taken = 1'b1; hz.load_in_ex_mem = 1'b1; hz.ex_dst_addr = 5'd3;
                           hz.id_rs1_rd_en = 1'b1; hz.id_rs1_addr = 5'd3; #1; end
         n_total++; if (ctl() !== C_STALL || hz.ctrl_state !== 2'd1)
            $display("FAIL mw_wait%0d got=%b/%0d exp=%b/1", i, ctl(), hz.ctrl_state, C_STALL); else n_pass++;
      end
      cyc();
      hz.dmem_ack = 1'b1; #1;
      n_total++; if (ctl() !== C_STALL || hz.ctrl_state !== 2'd1)
         $display("FAIL mw_ack got=%b/%0d exp=%b/1", ctl(), hz.ctrl_state, C_STALL); else n_pass++;
      cyc();
      n_total++; if (ctl() !== C_NONE || hz.ctrl_state !== 2'd0)
         $display("FAIL mw_done got=%b/%0d exp=%b/0", ctl(), hz.ctrl_state, C_NONE); else n_pass++;
      hz.dmem_req = 1'b1; hz.dmem_ack = 1'b1; #1;
      n_total++; if (ctl() !== C_NONE) $display("FAIL mw_zero_wait got=%b exp=%b", ctl(), C_NONE); else n_pass++;
      cyc();
      n_total++; if (hz.ctrl_state !== 2'd0) $display("FAIL mw_zero_wait_st got=%0d exp=0", hz.ctrl_state); else n_pass++;
   endtask

   task automatic test_branch_vs_lu();
      cyc();
      hz.branch_taken = 1'b1; hz.load_in_ex_mem = 1'b1; hz.ex_dst_addr = 5'd5;
      hz.id_rs2_rd_en = 1'b1; hz.id_rs2_addr = 5'd5; #1;
      n_total++; if (ctl() !== C_BR) $display("FAIL br_over_lu got=%b exp=%b", ctl(), C_BR); else n_pass++;
      cyc();
      n_total++; if (ctl() !== C_NONE || hz.ctrl_state !== 2'd0)
         $display("FAIL br_after got=%b/%0d exp=%b/0", ctl(), hz.ctrl_state, C_NONE); else n_pass++;
   endtask

   task automatic test_trap_run();
      cyc();
      hz.trap_req = 1'b1; hz.branch_taken = 1'b1; hz.dmem_req = 1'b1; #1;
      n_total++; if (ctl() !== C_NONE || hz.ctrl_state !== 2'd0)
         $display("FAIL trap_req_cyc got=%b/%0d exp=%b/0", ctl(), hz.ctrl_state, C_NONE); else n_pass++;
      cyc();
      hz.trap_req = 1'b1; #1;  // ignored while flushing
      n_total++; if (ctl() !== C_TRAP || hz.ctrl_state !== 2'd2)
         $display("FAIL trap_flush got=%b/%0d exp=%b/2", ctl(), hz.ctrl_state, C_TRAP); else n_pass++;
      cyc();
      n_total++; if (ctl() !== C_NONE || hz.ctrl_state !== 2'd0)
         $display("FAIL trap_back_run got=%b/%0d exp=%b/0", ctl(), hz.ctrl_state, C_NONE); else n_pass++;
   endtask

   task automatic test_trap_mem_wait();
      cyc();
      hz.dmem_req = 1'b1; #1;
      cyc();
      hz.trap_req = 1'b1; #1;  // wait cycle 1
      n_total++; if (ctl() !== C_STALL || hz.ctrl_state !== 2'd1)
         $display("FAIL tmw_w1 got=%b/%0d exp=%b/1", ctl(), hz.ctrl_state, C_STALL); else n_pass++;
      cyc();  // wait cycle 2
      n_total++; if (ctl() !== C_STALL || hz.ctrl_state !== 2'd1)
         $display("FAIL tmw_w2 got=%b/%0d exp=%b/1", ctl(), hz.ctrl_state, C_STALL); else n_pass++;
      cyc();
      hz.dmem_ack = 1'b1; #1;  // wait cycle 3 with ack
      n_total++; if (ctl() !== C_STALL || hz.ctrl_state !== 2'd1)
         $display("FAIL tmw_ack got=%b/%0d exp=%b/1", ctl(), hz.ctrl_state, C_STALL); else n_pass++;
      cyc();
      n_total++; if (ctl() !== C_TRAP || hz.ctrl_state !== 2'd2)
         $display("FAIL tmw_trap got=%b/%0d exp=%b/2", ctl(), hz.ctrl_state, C_TRAP); else n_pass++;
      cyc();
      n_total++; if (hz.ctrl_state !== 2'd0) $display("FAIL tmw_run got=%0d exp=0", hz.ctrl_state); else n_pass++;
      // trap raised in the ack cycle itself
      hz.dmem_req = 1'b1; #1;
      cyc();
      hz.dmem_ack = 1'b1; hz.trap_req = 1'b1; #1;
      cyc();
      n_total++; if (hz.ctrl_state !== 2'd2) $display("FAIL tmw_ack_trap got=%0d exp=2", hz.ctrl_state); else n_pass++;
      cyc();
      // pending trap must have cleared: a plain access returns to RUN
      hz.dmem_req = 1'b1; #1;
      cyc();
      hz.dmem_ack = 1'b1; #1;
      cyc();
      n_total++; if (hz.ctrl_state !== 2'd0) $display("FAIL tmw_pend_clr got=%0d exp=0", hz.ctrl_state); else n_pass++;
   endtask

   task automatic test_cpu_en();
      cyc();
      hz.dmem_req = 1'b1; #1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         hz.cpu_en = 1'b0; hz.dmem_ack = 1'b1; #1;
         n_total++; if (hz.ctrl_state !== 2'd1 || ctl() !== C_STALL)
            $display("FAIL en_hold%0d got=%0d/%b exp=1/%b", i, hz.ctrl_state, ctl(), C_STALL); else n_pass++;
      end
      cyc();
      hz.dmem_ack = 1'b1; #1;
      cyc();
      n_total++; if (hz.ctrl_state !== 2'd0) $display("FAIL en_resume got=%0d exp=0", hz.ctrl_state); else n_pass++;
      hz.cpu_en = 1'b0; hz.trap_req = 1'b1; #1;
      cyc();
      n_total++; if (hz.ctrl_state !== 2'd0) $display("FAIL en_trap_hold got=%0d exp=0", hz.ctrl_state); else n_pass++;
   endtask

   task automatic test_reset_mid();
      cyc();
      hz.trap_req = 1'b1; #1;
      cyc();
      n_total++; if (hz.ctrl_state !== 2'd2) $display("FAIL rst_pre_trap got=%0d exp=2", hz.ctrl_state); else n_pass++;
      rst_n = 1'b0; #1;
      n_total++; if (hz.ctrl_state !== 2'd0 || hz.trap_redirect !== 1'b0)
         $display("FAIL rst_mid_trap got=%0d/%b exp=0/0", hz.ctrl_state, hz.trap_redirect); else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      // reset in MEM_WAIT with a trap pending drops the trap
      cyc();
      hz.dmem_req = 1'b1; #1;
      cyc();
      hz.trap_req = 1'b1; #1;
      cyc();
      rst_n = 1'b0; #1;
      n_total++; if (hz.ctrl_state !== 2'd0) $display("FAIL rst_mid_mw got=%0d exp=0", hz.ctrl_state); else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      cyc();
      hz.dmem_req = 1'b1; #1;
      cyc();
      hz.dmem_ack = 1'b1; #1;
      cyc();
      n_total++; if (hz.ctrl_state !== 2'd0) $display("FAIL rst_pend_drop got=%0d exp=0", hz.ctrl_state); else n_pass++;
   endtask

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   task automatic test_perf();
      @(negedge clk); rst_n = 1'b0; idle_inputs(); #1;
      n_total++; if (hz.perf_lu_stall_cnt !== 32'd0 || hz.perf_mem_stall_cnt !== 32'd0 || hz.perf_flush_cnt !== 32'd0)
         $display("FAIL perf_reset got=%0d/%0d/%0d exp=0/0/0", hz.perf_lu_stall_cnt, hz.perf_mem_stall_cnt, hz.perf_flush_cnt); else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      cyc();
      hz.load_in_ex_mem = 1'b1; hz.ex_dst_addr = 5'd4; hz.id_rs1_rd_en = 1'b1; hz.id_rs1_addr = 5'd4; #1;
      cyc();
      hz.dmem_req = 1'b1; #1;
      cyc();
      hz.dmem_ack = 1'b1; #1;
      cyc();
      hz.branch_taken = 1'b1; #1;
      cyc();
      n_total++; if (hz.perf_lu_stall_cnt !== 32'd1 || hz.perf_mem_stall_cnt !== 32'd2 || hz.perf_flush_cnt !== 32'd1)
         $display("FAIL perf_counts got=%0d/%0d/%0d exp=1/2/1", hz.perf_lu_stall_cnt, hz.perf_mem_stall_cnt, hz.perf_flush_cnt); else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_load_use();
      test_mem_wait();
      test_branch_vs_lu();
      test_trap_run();
      test_trap_mem_wait();
      test_cpu_en();
      test_reset_mid();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives the hold (`*_stall`) and bubble (`*_flush`) controls of the IF, ID, EX and MEM pipeline registers.
- Detects load-use hazards, freezes the pipe while a data-memory access waits for ack, squashes wrong-path instructions on a taken branch, and runs a flush/redirect sequence on traps.
- Sits beside cpu_ctrl; outputs fan out to every stage register.

Parameters:
- GPR_ADDR_W, 5, width of register-file addresses.
- PERF_CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- cpu_en  in  1  global enable; FSM and counters hold when low.
- id_rs1_addr  in  GPR_ADDR_W  rs1 of the instruction in ID.
- id_rs2_addr  in  GPR_ADDR_W  rs2 of the instruction in ID.
- id_rs1_rd_en  in  1  ID instruction reads rs1.
- id_rs2_rd_en  in  1  ID instruction reads rs2.
- load_in_ex_mem  in  1  valid GPR-writing load in the EX/MEM register.
- ex_dst_addr  in  GPR_ADDR_W  destination of that load.
- dmem_req  in  1  MEM stage is issuing a data-memory access this cycle.
- dmem_ack  in  1  data memory completes the access.
- branch_taken  in  1  EX resolved a taken branch/jump.
- trap_req  in  1  exception, ecall or ebreak request from cpu_ctrl.
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold the corresponding stage register.
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  clear the corresponding stage register to a bubble.
- trap_redirect  out  1  one-cycle pulse; PC mux selects the trap vector.
- ctrl_state  out  2  current FSM state, for debug.

Behaviour:
- Reset is asynchronous, active-low rst_n; clock is clk. On reset: state=RUN, trap_pend=0.
- Stall, flush and redirect outputs are combinational from state and inputs. With inactive inputs all are 0, and ctrl_state=2'd0.
- FSM states and encodings:
  - RUN=0: normal operation.
  - MEM_WAIT=1: pipe frozen while a memory access is outstanding.
  - TRAP=2: one-cycle flush and redirect.
- FSM advances only when cpu_en=1; otherwise state and trap_pend hold.
- RUN, transitions:
  - trap_req=1 -> TRAP. Highest priority; the same-cycle branch, hazard and memory request are ignored.
  - else dmem_req=1 and dmem_ack=0 -> MEM_WAIT.
  - else remain in RUN.
- RUN, outputs, evaluated in priority order:
  1. trap_req=1: all outputs 0 this cycle.
  2. dmem_req=1 and dmem_ack=0: all four stalls=1, no flushes.
  3. branch_taken=1: if_flush=1, id_flush=1, no stalls. This overrides load-use because the consumer is squashed.
  4. Load-use, when load_in_ex_mem=1, ex_dst_addr!=0, and (id_rs1_rd_en and id_rs1_addr==ex_dst_addr, or id_rs2_rd_en and id_rs2_addr==ex_dst_addr): if_stall=1, id_stall=1, ex_flush=1. Exactly one bubble is inserted per hazard occurrence.
  5. Otherwise all outputs 0.
- MEM_WAIT:
  - All four stalls=1; branch_taken and hazard logic are ignored.
  - trap_req while waiting sets trap_pend=1; the access is never abandoned.
  - On dmem_ack=1: go to TRAP if (trap_pend or trap_req), else to RUN. Stalls are still 1 in the ack cycle; the registers advance on the following cycle.
- TRAP:
  - if_flush, id_flush, ex_flush, mem_flush and trap_redirect all =1; no stalls.
  - trap_pend is cleared; trap_req is ignored.
  - Next state is RUN unconditionally.
- A zero-wait access (dmem_req and dmem_ack in the same RUN cycle) causes no stall.
- A reset in mid-MEM_WAIT or mid-TRAP returns to RUN with the pending trap dropped.
- Unused encoding 3 is recovered to RUN on the next enabled clock.

Optional Feature:
- PIPE_HAZARD_CTRL_PERF_EN defined:
  - Adds outputs perf_lu_stall_cnt, perf_mem_stall_cnt and perf_flush_cnt, each PERF_CNT_W wide.
  - Each increments by 1 on each enabled clock in which the load-use bubble, MEM_WAIT stall, or branch/trap flush respectively is asserted.
  - Counters saturate at all-ones and reset to 0.
- Not defined: these ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
1. Load-use: load_in_ex_mem=1, ex_dst_addr=5, id_rs2_rd_en=1, id_rs2_addr=5 -> if_stall=id_stall=ex_flush=1 for exactly 1 cycle. With ex_dst_addr=0 -> no stall.
2. Memory wait: dmem_req=1, dmem_ack low for 3 cycles -> ctrl_state=1 and all stalls=1 for 3 cycles plus the ack cycle, then RUN with stalls 0.
3. Branch versus load-use in the same cycle: branch_taken=1 and a hazard -> if_flush=id_flush=1, if_stall=0, ex_flush=0.
4. Trap in RUN: trap_req pulse -> next cycle ctrl_state=2, all flushes=1, trap_redirect=1 for 1 cycle, then RUN.
5. Trap during MEM_WAIT: trap_req in wait cycle 1, ack in cycle 3 -> TRAP entered the cycle after ack, not before.
6. cpu_en=0 held in MEM_WAIT with dmem_ack=1 -> state stays 1. Assert rst_n low mid-TRAP -> state=0, trap_redirect=0.
